// File: rtl/simon_seq_engine.sv
// Simon-style game core: grows an LFSR symbol sequence, replays it on NCH lines,
// checks player presses, and tracks score. Optional input timeout: SIMON_TIMEOUT_EN.
module simon_seq_engine #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned TICKS_ON  = 25_000_000,
  parameter int unsigned TICKS_OFF = 12_500_000,
  parameter int unsigned TICKS_END = 50_000_000,
  parameter int unsigned TICKS_TO  = 250_000_000,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NCH-1:0]               btn,
  output logic [NCH-1:0]               led,
  output logic [$clog2(DEPTH+1)-1:0]   score,
  output logic [3:0]                   state_o,
  output logic                         round_won,
  output logic                         game_lost,
  output logic                         game_won,
  output logic                         busy
);

  localparam int unsigned CW  = $clog2(NCH);
  localparam int unsigned LW  = $clog2(DEPTH + 1);
  localparam int unsigned IW  = $clog2(DEPTH);
  localparam int unsigned T_A = (TICKS_ON > TICKS_OFF) ? TICKS_ON : TICKS_OFF;
  localparam int unsigned T_B = (T_A > TICKS_END) ? T_A : TICKS_END;
`ifdef SIMON_TIMEOUT_EN
  localparam int unsigned T_MAX     = (T_B > TICKS_TO) ? T_B : TICKS_TO;
  localparam int unsigned WAIT_LOAD = TICKS_TO - 1;
`else
  // Without the timeout WAIT_IN parks with the timer at zero.
  localparam int unsigned T_MAX     = T_B;
  localparam int unsigned WAIT_LOAD = 0 * TICKS_TO;
`endif
  localparam int unsigned TW = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADD       = 4'd1,
    S_SHOW_ON   = 4'd2,
    S_SHOW_OFF  = 4'd3,
    S_WAIT_IN   = 4'd4,
    S_WAIT_REL  = 4'd5,
    S_CHECK     = 4'd6,
    S_ROUND_WIN = 4'd7,
    S_LOST      = 4'd8
  } state_t;

  state_t          state;
  logic [15:0]     lfsr;
  logic [LW-1:0]   len;
  logic [IW-1:0]   idx;
  logic [TW-1:0]   timer;
  logic            armed;
  logic [NCH-1:0]  pressed;
  logic [CW-1:0]   seq [DEPTH];

  logic            lfsr_fb;
  logic [CW-1:0]   sym;
  logic            last_idx;

  function automatic logic [NCH-1:0] dec(input logic [CW-1:0] s);
    return NCH'(1) << s;
  endfunction

  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign sym      = lfsr[CW-1:0];
  assign last_idx = (LW'(idx) == (len - LW'(1)));
  assign state_o  = state;

  // Sequence memory is never cleared; len bounds every read.
  always_ff @(posedge CLOCK_50) begin
    if (!reset && state == S_ADD && len < LW'(DEPTH))
      seq[IW'(len)] <= sym;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= S_IDLE;
      lfsr      <= SEED;
      len       <= '0;
      idx       <= '0;
      timer     <= '0;
      armed     <= 1'b0;
      pressed   <= '0;
      led       <= '0;
      score     <= '0;
      round_won <= 1'b0;
      game_lost <= 1'b0;
      game_won  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      lfsr      <= {lfsr[14:0], lfsr_fb};
      round_won <= 1'b0;
      game_lost <= 1'b0;
      game_won  <= 1'b0;
      if (timer != '0) timer <= timer - TW'(1);

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ADD;
            score <= '0;
            len   <= '0;
            busy  <= 1'b1;
          end
        end

        S_ADD: begin
          if (len < LW'(DEPTH)) len <= len + LW'(1);
          idx   <= '0;
          state <= S_SHOW_ON;
          timer <= TW'(TICKS_ON - 1);
          // On the first round seq[0] is being written this cycle.
          led   <= dec((len == '0) ? sym : seq[0]);
        end

        S_SHOW_ON: begin
          if (timer == '0) begin
            state <= S_SHOW_OFF;
            led   <= '0;
            timer <= TW'(TICKS_OFF - 1);
          end
        end

        S_SHOW_OFF: begin
          if (timer == '0) begin
            if (last_idx) begin
              idx   <= '0;
              state <= S_WAIT_IN;
              armed <= 1'b0;
              timer <= TW'(WAIT_LOAD);
            end else begin
              idx   <= idx + IW'(1);
              state <= S_SHOW_ON;
              led   <= dec(seq[idx + IW'(1)]);
              timer <= TW'(TICKS_ON - 1);
            end
          end
        end

        // A press counts only after btn has been seen at zero in this state.
        S_WAIT_IN: begin
          if (armed && btn != '0) begin
            if (btn == dec(seq[idx])) begin
              state   <= S_WAIT_REL;
              led     <= btn;
              pressed <= btn;
            end else begin
              state     <= S_LOST;
              game_lost <= 1'b1;
              timer     <= TW'(TICKS_END - 1);
            end
          end
`ifdef SIMON_TIMEOUT_EN
          else if (timer == '0) begin
            state     <= S_LOST;
            game_lost <= 1'b1;
            timer     <= TW'(TICKS_END - 1);
          end
`endif
          if (btn == '0) armed <= 1'b1;
        end

        S_WAIT_REL: begin
          if (btn == '0) begin
            state <= S_CHECK;
            led   <= '0;
          end else if ((btn & ~pressed) != '0) begin
            state     <= S_LOST;
            led       <= '0;
            game_lost <= 1'b1;
            timer     <= TW'(TICKS_END - 1);
          end
        end

        S_CHECK: begin
          if (last_idx) begin
            state     <= S_ROUND_WIN;
            round_won <= 1'b1;
            timer     <= TW'(TICKS_END - 1);
            if (score != LW'(DEPTH)) score <= score + LW'(1);
          end else begin
            idx   <= idx + IW'(1);
            state <= S_WAIT_IN;
            armed <= 1'b0;
            timer <= TW'(WAIT_LOAD);
          end
        end

        S_ROUND_WIN: begin
          if (timer == '0) begin
            if (len == LW'(DEPTH)) begin
              state    <= S_IDLE;
              game_won <= 1'b1;
              busy     <= 1'b0;
            end else begin
              state <= S_ADD;
            end
          end
        end

        S_LOST: begin
          if (timer == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          led   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
